// File: rtl/core_pkg.sv
// Shared CDB widths and the broadcast packet type used by the arbiter,
// reservation stations and ROB.
package core_pkg;

    localparam int CDB_W  = 2;
    localparam int PHYS_W = 6;
    localparam int ROB_W  = 6;

    typedef struct packed {
        logic [PHYS_W-1:0] tag;
        logic [63:0]       value;
        logic [ROB_W-1:0]  rob_tag;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_rr_multi_pick.sv
// Rotating-priority selector: grants up to K requests per cycle, scanning from
// start upward (mod N) and filling the lowest slots first. Purely combinational.
module rr_multi_pick #(
    parameter int N  = 4,
    parameter int K  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]          req,
    input  logic [IW-1:0]         start,
    output logic [K-1:0][N-1:0]   grant,
    output logic [K-1:0]          slot_valid,
    output logic [K-1:0][IW-1:0]  slot_idx,
    output logic [IW-1:0]         next_ptr
);

    always_comb begin
        int          sum;
        logic        placed;
        logic [IW-1:0] idx;
        grant      = '0;
        slot_valid = '0;
        slot_idx   = '0;
        next_ptr   = start;
        sum        = 0;
        placed     = 1'b0;
        idx        = '0;
        for (int off = 0; off < N; off++) begin
            sum    = int'(start) + off;
            idx    = IW'((sum >= N) ? sum - N : sum);
            placed = 1'b0;
            for (int k = 0; k < K; k++) begin
                if (req[idx] && !placed && !slot_valid[k]) begin
                    grant[k][idx] = 1'b1;
                    slot_valid[k] = 1'b1;
                    slot_idx[k]   = idx;
                    // Pointer moves past the most recent (highest-slot) winner.
                    next_ptr      = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
                    placed        = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one-entry holding buffer per functional unit,
// rotating-priority pick of up to CDB_W results, registered CDB outputs.
module cdb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int CDB_W  = core_pkg::CDB_W,
    parameter int PHYS_W = core_pkg::PHYS_W,
    parameter int ROB_W  = core_pkg::ROB_W,
    parameter int SRC_W  = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ-1:0][PHYS_W-1:0]  req_tag,
    input  logic [N_REQ-1:0][63:0]        req_value,
    input  logic [N_REQ-1:0][ROB_W-1:0]   req_rob_tag,
    output logic [CDB_W-1:0]              cdb_valid,
    output logic [CDB_W-1:0][PHYS_W-1:0]  cdb_tag,
    output logic [CDB_W-1:0][63:0]        cdb_value,
    output logic [CDB_W-1:0][ROB_W-1:0]   cdb_rob_tag,
    output logic [CDB_W-1:0][SRC_W-1:0]   cdb_src
);

    core_pkg::cdb_pkt_t              buf_pkt [N_REQ];
    logic [N_REQ-1:0]                buf_valid;
    logic [SRC_W-1:0]                rr_ptr_reg;
    logic [SRC_W-1:0]                rr_ptr_next;
    logic [CDB_W-1:0][N_REQ-1:0]     grant;
    logic [CDB_W-1:0]                slot_valid;
    logic [CDB_W-1:0][SRC_W-1:0]     slot_idx;
    logic [N_REQ-1:0]                grant_any;

    rr_multi_pick #(
        .N  (N_REQ),
        .K  (CDB_W),
        .IW (SRC_W)
    ) u_pick (
        .req        (buf_valid),
        .start      (rr_ptr_reg),
        .grant      (grant),
        .slot_valid (slot_valid),
        .slot_idx   (slot_idx),
        .next_ptr   (rr_ptr_next)
    );

    always_comb begin
        grant_any = '0;
        for (int k = 0; k < CDB_W; k++) begin
            grant_any = grant_any | grant[k];
        end
    end

    // A buffer being drained this cycle may be refilled on the same edge.
    assign req_ready = {N_REQ{~reset & ~flush}} & (~buf_valid | grant_any);

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_buf
            logic               valid_reg;
            core_pkg::cdb_pkt_t pkt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                end else if (req_valid[gi] && req_ready[gi]) begin
                    valid_reg <= 1'b1;
                end else if (grant_any[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            // Payload is only meaningful while valid_reg is set.
            always_ff @(posedge clk) begin
                if (req_valid[gi] && req_ready[gi]) begin
                    pkt_reg <= '{tag: req_tag[gi], value: req_value[gi], rob_tag: req_rob_tag[gi]};
                end
            end

            assign buf_valid[gi] = valid_reg;
            assign buf_pkt[gi]   = pkt_reg;
        end

        for (gi = 0; gi < CDB_W; gi++) begin : g_slot
            logic               valid_reg;
            core_pkg::cdb_pkt_t pkt_reg;
            logic [SRC_W-1:0]   src_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    pkt_reg   <= '0;
                    src_reg   <= '0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                    pkt_reg   <= '0;
                    src_reg   <= '0;
                end else begin
                    valid_reg <= slot_valid[gi];
                    pkt_reg   <= slot_valid[gi] ? buf_pkt[slot_idx[gi]] : '0;
                    src_reg   <= slot_valid[gi] ? slot_idx[gi] : '0;
                end
            end

            assign cdb_valid[gi]   = valid_reg;
            assign cdb_tag[gi]     = pkt_reg.tag;
            assign cdb_value[gi]   = pkt_reg.value;
            assign cdb_rob_tag[gi] = pkt_reg.rob_tag;
            assign cdb_src[gi]     = src_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_reg <= '0;
        end else if (flush) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed test-plan scenarios followed by randomized traffic, all checked
// against a rule-level model of the buffers, rotation pointer and CDB slots.
module tb_cdb_arbiter;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic [3:0]       req_valid = '0;
    logic [3:0]       req_ready;
    logic [3:0][5:0]  req_tag = '0;
    logic [3:0][63:0] req_value = '0;
    logic [3:0][5:0]  req_rob_tag = '0;
    logic [1:0]       cdb_valid;
    logic [1:0][5:0]  cdb_tag;
    logic [1:0][63:0] cdb_value;
    logic [1:0][5:0]  cdb_rob_tag;
    logic [1:0][1:0]  cdb_src;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_tag     (req_tag),
        .req_value   (req_value),
        .req_rob_tag (req_rob_tag),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value),
        .cdb_rob_tag (cdb_rob_tag),
        .cdb_src     (cdb_src)
    );

    // Reference model: buffered results per unit, rotation start, expected CDB.
    bit          m_valid [4];
    logic [63:0] m_tag [4];
    logic [63:0] m_value [4];
    logic [63:0] m_rob [4];
    int          m_ptr;
    bit          e_valid [2];
    logic [63:0] e_tag [2];
    logic [63:0] e_value [2];
    logic [63:0] e_rob [2];
    logic [63:0] e_src [2];
    logic [3:0]  acc_mask;
    logic [3:0]  pend;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", name, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_valid[i] = 0;
        for (int k = 0; k < 2; k++) begin
            e_valid[k] = 0; e_tag[k] = 0; e_value[k] = 0; e_rob[k] = 0; e_src[k] = 0;
        end
        m_ptr = 0;
    endtask

    task automatic check_cdb();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("cdb_valid[%0d]", k), 64'(cdb_valid[k]), 64'(e_valid[k]));
            chk($sformatf("cdb_tag[%0d]", k), 64'(cdb_tag[k]), e_tag[k]);
            chk($sformatf("cdb_value[%0d]", k), cdb_value[k], e_value[k]);
            chk($sformatf("cdb_rob_tag[%0d]", k), 64'(cdb_rob_tag[k]), e_rob[k]);
            chk($sformatf("cdb_src[%0d]", k), 64'(cdb_src[k]), e_src[k]);
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        int         picks[$];
        bit         granted [4];
        logic [3:0] exp_ready;
        int         i;
        check_cdb();
        #1;
        picks = {};
        for (int off = 0; off < 4; off++) begin
            i = (m_ptr + off) % 4;
            if (m_valid[i] && picks.size() < 2) picks.push_back(i);
        end
        for (int n = 0; n < 4; n++) granted[n] = 0;
        foreach (picks[j]) granted[picks[j]] = 1;
        for (int n = 0; n < 4; n++) exp_ready[n] = !flush && (!m_valid[n] || granted[n]);
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        if (flush) begin
            model_clear();
            acc_mask = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (k < picks.size()) begin
                    e_valid[k] = 1;
                    e_tag[k] = m_tag[picks[k]];
                    e_value[k] = m_value[picks[k]];
                    e_rob[k] = m_rob[picks[k]];
                    e_src[k] = 64'(picks[k]);
                end else begin
                    e_valid[k] = 0; e_tag[k] = 0; e_value[k] = 0; e_rob[k] = 0; e_src[k] = 0;
                end
            end
            acc_mask = req_valid & exp_ready;
            for (int n = 0; n < 4; n++) begin
                if (acc_mask[n]) begin
                    m_valid[n] = 1;
                    m_tag[n] = 64'(req_tag[n]);
                    m_value[n] = req_value[n];
                    m_rob[n] = 64'(req_rob_tag[n]);
                end else if (granted[n]) begin
                    m_valid[n] = 0;
                end
            end
            if (picks.size() > 0) m_ptr = (picks[picks.size() - 1] + 1) % 4;
        end
        $display("cycle t=%0t valid=%b ready=%b flush=%b -> grants=%0d", $time, req_valid, exp_ready, flush, picks.size());
        @(negedge clk);
    endtask

    task automatic set_req(input int n, input int tag, input longint value, input int rob);
        req_tag[n] = 6'(tag);
        req_value[n] = 64'(value);
        req_rob_tag[n] = 6'(rob);
    endtask

    task automatic drain();
        req_valid = '0;
        flush = 1'b0;
        repeat (3) step();
    endtask

    int tbl_src0 [3] = '{0, 2, 0};
    int tbl_src1 [3] = '{1, 3, 1};

    initial begin
        model_clear();
        acc_mask = '0;
        pend = '0;

        // Reset state
        #1 reset = 1'b1;
        #2;
        chk("reset_req_ready", 64'(req_ready), 64'h0);
        chk("reset_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("reset_cdb_value0", cdb_value[0], 64'h0);
        chk("reset_cdb_tag1", 64'(cdb_tag[1]), 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 64'(req_ready), 64'hF);

        // Single result on unit 2
        req_valid = 4'b0100;
        set_req(2, 10, 8, 0);
        step();
        req_valid = '0;
        step();
        chk("t1_cdb_valid", 64'(cdb_valid), 64'b01);
        chk("t1_cdb_tag0", 64'(cdb_tag[0]), 64'd10);
        chk("t1_cdb_value0", cdb_value[0], 64'd8);
        chk("t1_cdb_src0", 64'(cdb_src[0]), 64'd2);
        chk("t1_ready2", 64'(req_ready[2]), 64'd1);
        step();

        // All four units continuously valid, rotation from 0
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int n = 0; n < 4; n++) set_req(n, 20 + n, 100 + n, n);
        req_valid = 4'hF;
        step();
        for (int j = 0; j < 3; j++) begin
            step();
            chk("t2_cdb_valid", 64'(cdb_valid), 64'b11);
            chk("t2_src0", 64'(cdb_src[0]), 64'(tbl_src0[j]));
            chk("t2_src1", 64'(cdb_src[1]), 64'(tbl_src1[j]));
        end
        drain();

        // Back-to-back on unit 0
        req_valid = 4'b0001;
        set_req(0, 5, 1, 1);
        step();
        set_req(0, 5, 2, 2);
        step();
        chk("t3_value_1", cdb_value[0], 64'd1);
        set_req(0, 5, 3, 3);
        step();
        chk("t3_value_2", cdb_value[0], 64'd2);
        req_valid = '0;
        step();
        chk("t3_value_3", cdb_value[0], 64'd3);
        drain();

        // Units 1 and 3 with rotation pointer at 2
        flush = 1'b1;
        step();
        flush = 1'b0;
        req_valid = 4'b0011;
        set_req(0, 30, 300, 10);
        set_req(1, 31, 301, 11);
        step();
        req_valid = 4'b1010;
        set_req(1, 41, 401, 21);
        set_req(3, 43, 403, 23);
        step();
        req_valid = 4'b0110;
        set_req(1, 51, 501, 31);
        set_req(2, 52, 502, 32);
        step();
        chk("t4_cdb_valid", 64'(cdb_valid), 64'b11);
        chk("t4_src0", 64'(cdb_src[0]), 64'd3);
        chk("t4_src1", 64'(cdb_src[1]), 64'd1);
        req_valid = '0;
        step();
        chk("t4_ptr_src0", 64'(cdb_src[0]), 64'd2);
        chk("t4_ptr_src1", 64'(cdb_src[1]), 64'd1);
        drain();

        // Flush with three buffered results and a new request
        req_valid = 4'b0111;
        for (int n = 0; n < 3; n++) set_req(n, 60 + n, 600 + n, n);
        step();
        req_valid = 4'b1000;
        set_req(3, 63, 603, 3);
        flush = 1'b1;
        step();
        chk("t5_cdb_valid_flush", 64'(cdb_valid), 64'h0);
        flush = 1'b0;
        step();
        req_valid = '0;
        step();
        chk("t5_cdb_valid_after", 64'(cdb_valid), 64'b01);
        chk("t5_src0_after", 64'(cdb_src[0]), 64'd3);
        drain();

        // Asynchronous reset while two results are on the CDB
        req_valid = 4'b0011;
        set_req(0, 7, 70, 7);
        set_req(1, 8, 80, 8);
        step();
        req_valid = '0;
        step();
        chk("t6_cdb_valid_pre", 64'(cdb_valid), 64'b11);
        #2 reset = 1'b1;
        #1;
        chk("t6_cdb_valid_async", 64'(cdb_valid), 64'h0);
        chk("t6_ready_in_reset", 64'(req_ready), 64'h0);
        @(negedge clk);
        chk("t6_ready_held", 64'(req_ready), 64'h0);
        reset = 1'b0;
        model_clear();
        step();

        // Randomized traffic with occasional flushes
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 4; n++) begin
                if (!pend[n]) begin
                    req_valid[n] = ($urandom_range(0, 9) < 6);
                    req_tag[n] = 6'($urandom);
                    req_value[n] = {$urandom, $urandom};
                    req_rob_tag[n] = 6'($urandom);
                end
            end
            flush = ($urandom_range(0, 29) == 0);
            step();
            pend = req_valid & ~acc_mask;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
